regfile_write_arbiter: RTL and testbench

//  Owns the single write port of the 8x8 register file and shares it between two writers:

---
 rtl/regfile_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single write port of the register file and
// shares it between requester 0 (ALU writeback) and requester 1 (switch/IO load)
// using round-robin arbitration with a req/gnt handshake. All outputs are registered.
// A built-in clear sequencer zeroes registers 1..NUM_REGS-1 on demand.
// Optional feature macro: REGARB_R0_DROP_EN. When it is defined, a granted write to
// address 0 is dropped: the grant still pulses, but write_enable stays low.
module regfile_write_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;          // last address written by the clear sequence
    logic              last_gnt, last_gnt_n;
    logic              gnt0_n, gnt1_n, busy_n, done_n, we_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [DATA_W-1:0] wdata_n;

    // A requester already holding a grant this cycle is ignored until it updates req.
    logic              elig0, elig1, win_vld, win_sel, do_arb;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Round-robin pick between eligible requesters; ties go to the one not granted last.
    always_comb begin
        elig0    = req0 & ~gnt0;
        elig1    = req1 & ~gnt1;
        win_vld  = elig0 | elig1;
        win_sel  = 1'b0;
        if (elig0 && elig1)
            win_sel = ~last_gnt;
        else if (elig1)
            win_sel = 1'b1;
        win_addr = win_sel ? addr1 : addr0;
        win_data = win_sel ? data1 : data0;
    end

    // Next-state and next-output logic for the ARB/CLEAR controller.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_gnt_n = last_gnt;
        gnt0_n     = 1'b0;
        gnt1_n     = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
        we_n       = 1'b0;
        waddr_n    = write_address;
        wdata_n    = write_data;
        do_arb     = 1'b0;

        case (state)
            ARB: begin
                if (clear_start) begin
                    // Clear takes priority: first zeroing write goes out on the next edge.
                    state_n = CLEAR;
                    busy_n  = 1'b1;
                    cnt_n   = ADDR_W'(1);
                    we_n    = 1'b1;
                    waddr_n = ADDR_W'(1);
                    wdata_n = '0;
                end else begin
                    do_arb = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    // Sequence finished; pending requests may be served on this same edge.
                    state_n = ARB;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    do_arb  = 1'b1;
                end else begin
                    cnt_n   = cnt + ADDR_W'(1);
                    we_n    = 1'b1;
                    waddr_n = cnt + ADDR_W'(1);
                    wdata_n = '0;
                end
            end
            default: state_n = ARB;
        endcase

        if (do_arb && win_vld) begin
            gnt0_n     = ~win_sel;
            gnt1_n     = win_sel;
            last_gnt_n = win_sel;
`ifdef REGARB_R0_DROP_EN
            if (win_addr != '0) begin
                we_n    = 1'b1;
                waddr_n = win_addr;
                wdata_n = win_data;
            end
`else
            we_n    = 1'b1;
            waddr_n = win_addr;
            wdata_n = win_data;
`endif
        end
    end

    // State, counter and registered write-port outputs.
    always_ff @(posedge clock_reg) begin
        if (reset) begin
            state         <= ARB;
            cnt           <= '0;
            last_gnt      <= 1'b1;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            last_gnt      <= last_gnt_n;
            gnt0          <= gnt0_n;
            gnt1          <= gnt1_n;
            busy          <= busy_n;
            clear_done    <= done_n;
            write_enable  <= we_n;
            write_address <= waddr_n;
            write_data    <= wdata_n;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic       clock_reg = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, clear_start = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, busy, clear_done, write_enable;
    logic [2:0] write_address;
    logic [7:0] write_data;

    int checks = 0;
    int errors = 0;
    int n_wr, n_done;

    regfile_write_arbiter dut (
        .clock_reg(clock_reg), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data)
    );

    always #5 clock_reg = ~clock_reg;

    task automatic step();
        @(posedge clock_reg);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full write port plus grants in one call.
    task automatic port(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d,
                        input logic g0, input logic g1);
        chk({tag, ".we"}, 32'(write_enable), 32'(we));
        chk({tag, ".addr"}, 32'(write_address), 32'(a));
        chk({tag, ".data"}, 32'(write_data), 32'(d));
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
    endtask

    initial begin
        // ---- Reset state ----
        reset = 1'b1;
        step(); step();
        port("rst", 0, 3'd0, 8'h00, 0, 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(clear_done), 0);

        // ---- Test 1: single request, 1-cycle latency ----
        reset = 1'b0; req0 = 1'b1; addr0 = 3'd3; data0 = 8'hA5;
        step();
        port("t1", 1, 3'd3, 8'hA5, 1, 0);
        req0 = 1'b0;
        step();
        port("t1.idle", 0, 3'd3, 8'hA5, 0, 0);

        // ---- Test 2: both held -> alternate starting with 0 after reset ----
        reset = 1'b1; step(); reset = 1'b0;
        req0 = 1'b1; addr0 = 3'd2; data0 = 8'h11;
        req1 = 1'b1; addr1 = 3'd5; data1 = 8'h22;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 0) port($sformatf("t2.c%0d", i), 1, 3'd2, 8'h11, 1, 0);
            else            port($sformatf("t2.c%0d", i), 1, 3'd5, 8'h22, 0, 1);
        end

        // ---- Test 3: clear with req1 pending ----
        req0 = 1'b0;
        req1 = 1'b1; addr1 = 3'd6; data1 = 8'h66;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        chk("t3.busy", 32'(busy), 1);
        port("t3.w1", 1, 3'd1, 8'h00, 0, 0);
        for (int a = 2; a <= 7; a++) begin
            step();
            port($sformatf("t3.w%0d", a), 1, 3'(a), 8'h00, 0, 0);
            chk($sformatf("t3.busy%0d", a), 32'(busy), 1);
            chk($sformatf("t3.nodone%0d", a), 32'(clear_done), 0);
        end
        step();
        chk("t3.done", 32'(clear_done), 1);
        chk("t3.busy_lo", 32'(busy), 0);
        port("t3.grant", 1, 3'd6, 8'h66, 0, 1);
        req1 = 1'b0;
        step();
        chk("t3.done_pulse", 32'(clear_done), 0);
        port("t3.after", 0, 3'd6, 8'h66, 0, 0);

        // ---- Test 6: clear_start re-pulsed while busy ----
        n_wr = 0; n_done = 0;
        clear_start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 3) clear_start = 1'b1;
            else        clear_start = 1'b0;
            if (write_enable) n_wr++;
            if (clear_done) n_done++;
        end
        chk("t6.writes", 32'(n_wr), 7);
        chk("t6.dones", 32'(n_done), 1);

        // ---- Test 4: reset during clear ----
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        step();
        step();
        port("t4.w3", 1, 3'd3, 8'h00, 0, 0);
        reset = 1'b1;
        step();
        port("t4.rst", 0, 3'd0, 8'h00, 0, 0);
        chk("t4.busy", 32'(busy), 0);
        chk("t4.done", 32'(clear_done), 0);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (clear_done) n_done++;
        end
        chk("t4.nodone", 32'(n_done), 0);
        req0 = 1'b1; addr0 = 3'd4; data0 = 8'h44;
        step();
        port("t4.req0", 1, 3'd4, 8'h44, 1, 0);

        // ---- Test 5: write to address 0 ----
        req0 = 1'b0;
        req1 = 1'b1; addr1 = 3'd0; data1 = 8'h55;
        step();
`ifdef REGARB_R0_DROP_EN
        port("t5.drop", 0, 3'd4, 8'h44, 0, 1);
`else
        port("t5.fwd", 1, 3'd0, 8'h55, 0, 1);
`endif
        req1 = 1'b0;
        step();
        chk("t5.idle_we", 32'(write_enable), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
